seq_divider: RTL and testbench



---
 rtl/seq_divider_if.sv | 30 +++
 rtl/seq_divider.sv | 144 ++++++++++++++
 tb/tb_seq_divider.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if: EX-stage <-> divider handshake bundle.
//   signed_div_i : 1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held until ready_o is seen
//   annul_i      : cancel the current operation
//   result_o     : {remainder (HI), quotient (LO)}
//   ready_o      : result valid
// master = EX stage, slave = divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider with MIPS sign rules.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   div_if : seq_divider_if slave (operands, start/annul, result/ready)
// One quotient bit per cycle; ready_o rises WIDTH edges after acceptance,
// or one edge after acceptance when the divisor is zero (result 0).
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave div_if
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     quo_q, quo_d;       // |dividend| shifting out, quotient shifting in
  logic [WIDTH-1:0]     rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH:0]       rem_shift;
  logic [WIDTH-1:0]     rem_sub;
  logic                 ge;
  logic [WIDTH-1:0]     rem_nxt, quo_nxt;
  logic                 op1_neg, op2_neg;

  // Stored remainder is always < |divisor|, so it fits in WIDTH bits; only
  // the shifted intermediate needs the extra bit.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    ge        = rem_shift >= {1'b0, divisor_q};
    rem_sub   = rem_shift[WIDTH-1:0] - divisor_q;
    rem_nxt   = ge ? rem_sub : rem_shift[WIDTH-1:0];
    quo_nxt   = {quo_q[WIDTH-2:0], ge};
    op1_neg   = div_if.signed_div_i & div_if.opdata1_i[WIDTH-1];
    op2_neg   = div_if.signed_div_i & div_if.opdata2_i[WIDTH-1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (div_if.start_i && !div_if.annul_i) begin
          neg_quo_d = op1_neg ^ op2_neg;
          neg_rem_d = op1_neg;
          quo_d     = op1_neg ? -div_if.opdata1_i : div_if.opdata1_i;
          divisor_d = op2_neg ? -div_if.opdata2_i : div_if.opdata2_i;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = (div_if.opdata2_i == '0) ? S_DIVZERO : S_ON;
        end
      end

      S_DIVZERO: begin
        result_d = '0;
        if (div_if.annul_i) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          ready_d = 1'b1;
          state_d = S_END;
        end
      end

      S_ON: begin
        if (div_if.annul_i) begin
          ready_d  = 1'b0;
          result_d = '0;
          state_d  = S_IDLE;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d = {(neg_rem_q ? -rem_nxt : rem_nxt),
                        (neg_quo_q ? -quo_nxt : quo_nxt)};
            ready_d  = 1'b1;
            state_d  = S_END;
          end
        end
      end

      S_END: begin
        if (div_if.annul_i || !div_if.start_i) begin
          ready_d  = 1'b0;
          result_d = '0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) dif ();

  seq_divider #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = int'(a);
    sb = int'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  // Drive one request, push expectation, wait (bounded) for ready_o,
  // check latency/result, optionally hold start_i, then release.
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold, input bit scramble);
    int n;
    int lat;
    bit seen;
    logic [63:0] want;
    lat  = (b == 32'd0) ? 2 : 33;
    seen = 1'b0;
    n    = 0;
    @(negedge clk);
    dif.signed_div_i = s;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
    sb_q.push_back(exp);
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (scramble && n == 3) begin
        dif.opdata1_i    = $urandom;
        dif.opdata2_i    = $urandom;
        dif.signed_div_i = ~s;
      end
      if (dif.ready_o) seen = 1'b1;
    end
    want = sb_q.pop_front();
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got no ready after %0d edges required %0d", n, lat);
    end else begin
      check("latency", 64'(n), 64'(lat));
      check("result", dif.result_o, want);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        check("hold_ready", 64'(dif.ready_o), 64'd1);
        check("hold_result", dif.result_o, want);
      end
    end
    @(negedge clk);
    dif.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("drop_ready", 64'(dif.ready_o), 64'd0);
    check("drop_result", dif.result_o, 64'd0);
  endtask

  initial begin
    vec_t vecs[8];
    bit rose;
    logic [31:0] ra, rb;
    bit rs;

    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;

    vecs[0] = '{0, 32'd100,        32'd7,        64'h00000002_0000000E};
    vecs[1] = '{1, 32'hFFFF_FFF9,  32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vecs[2] = '{1, 32'd7,          32'hFFFF_FFFE, 64'h00000001_FFFFFFFD};
    vecs[3] = '{1, 32'd1234,       32'd0,        64'h0};
    vecs[4] = '{0, 32'hFFFF_FFFF,  32'd0,        64'h0};
    vecs[5] = '{1, 32'h8000_0000,  32'hFFFF_FFFF, 64'h00000000_80000000};
    vecs[6] = '{0, 32'h8000_0000,  32'hFFFF_FFFF, 64'h80000000_00000000};
    vecs[7] = '{0, 32'hFFFF_FFFF,  32'd1,        64'h00000000_FFFFFFFF};

    #2;
    check("reset_ready", 64'(dif.ready_o), 64'd0);
    check("reset_result", dif.result_o, 64'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, 0, 0);

    // Hold start_i 3 cycles past ready; operands scrambled during ON.
    run_div(1, 32'hFFFF_FF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 3, 1);

    // Annul at iteration 10.
    rose = 1'b0;
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd100;
    dif.opdata2_i    = 32'd7;
    dif.start_i      = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (dif.ready_o) rose = 1'b1;
    end
    @(negedge clk);
    dif.annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul_ready", 64'(dif.ready_o), 64'd0);
    check("annul_result", dif.result_o, 64'd0);
    @(negedge clk);
    dif.annul_i = 1'b0;
    dif.start_i = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (dif.ready_o) rose = 1'b1;
    end
    check("annul_no_ready", 64'(rose), 64'd0);
    run_div(0, 32'd9, 32'd3, 64'h00000000_00000003, 0, 0);

    // Annul in IDLE blocks acceptance.
    rose = 1'b0;
    @(negedge clk);
    dif.opdata1_i = 32'd50;
    dif.opdata2_i = 32'd0;
    dif.start_i   = 1'b1;
    dif.annul_i   = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (dif.ready_o) rose = 1'b1;
    end
    check("idle_annul_block", 64'(rose), 64'd0);
    @(negedge clk);
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;

    // Async reset mid-ON, then async reset while ready_o is high.
    @(negedge clk);
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd3;
    dif.start_i   = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    check("pre_reset_ready", 64'(dif.ready_o), 64'd1);
    check("pre_reset_result", dif.result_o, 64'h00000001_0000014D);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ready", 64'(dif.ready_o), 64'd0);
    check("async_rst_result", dif.result_o, 64'd0);
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dif.start_i = 1'b1;
    repeat (12) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midon_rst_ready", 64'(dif.ready_o), 64'd0);
    check("midon_rst_result", dif.result_o, 64'd0);
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div(1, 32'hFFFF_FC18, 32'd3, 64'hFFFFFFFF_FFFFFEB3, 0, 0);

    // Random pairs against the reference model.
    for (int k = 0; k < 1500; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 20));
        3:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(rs, ra, rb, model(rs, ra, rb), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
